spi_word_deser: RTL
===================

# spi_word_deser

Parametrised full-duplex SPI word engine, the next generation of the 8-bit SPI shift-register deserializer. It runs entirely in the `spi_clk` domain, between the SPI pads and the register-file write logic. It deserialises `pico` into words of configurable width and bit order, and numbers each word within a `csb` burst. It also serialises a transmit word onto `poci` and flags bursts longer than the configured maximum.

## Interface
- `WORD_W`, 8: bits per word; must be ≥ 2.
- `MSB_FIRST`, 1: 1 = first received/transmitted bit is bit WORD_W-1; 0 = first bit is bit 0.
- `MAX_WORDS`, 4: words accepted per burst; must be ≥ 2.
- `IDX_W`, `$clog2(MAX_WORDS)`: derived width of `word_idx`; do not override.

- `spi_clk` in 1: sole clock; sampling and shifting on rising edge.
- `rstn` in 1: chip-wide reset, asynchronous, active-low.
- `csb` in 1: chip select, active-low; high acts as an asynchronous burst-local clear.
- `pico` in 1: serial data in.
- `tx_word` in WORD_W: word to transmit; must be stable from before the first edge of each word until that edge.
- `poci` out 1: serial data out.
- `word_out` out WORD_W: last accepted word.
- `word_valid` out 1: one-cycle strobe; `word_out`/`word_idx` were updated on the preceding edge.
- `word_idx` out IDX_W: index within the burst of the word in `word_out`.
- `overflow` out 1: sticky; a word completed after MAX_WORDS words had been accepted.

## Operation
- Internal state:
  - `bit_cnt`, 0..WORD_W-1.
  - `rx_shift`, WORD_W-1 bits.
  - `tx_shift`, WORD_W bits.
  - `words_done`, 0..MAX_WORDS, saturating.
- Asynchronous clear is `full_rstn = rstn & ~csb`.
  - `rstn` low clears everything: all outputs 0, `word_out` = 0, `word_idx` = 0.
  - `csb` high with `rstn` high clears `bit_cnt`, `rx_shift`, `tx_shift`, `words_done`, `word_valid` and `overflow`.
  - `word_out` and `word_idx` hold their values across `csb` high.
- Each rising edge with `full_rstn` high:
  - Shift `pico` into `rx_shift`. With MSB_FIRST=1, left shift, new bit at the LSB. With MSB_FIRST=0, right shift, new bit at the MSB.
  - `bit_cnt` increments and wraps WORD_W-1 → 0.
- Word completion occurs on the edge where `bit_cnt == WORD_W-1`. The assembled word is `rx_shift` combined with the current `pico`.
  - If `words_done < MAX_WORDS`: `word_out` ← assembled word, `word_idx` ← `words_done`, `words_done`++, `word_valid` ← 1.
  - Else: `word_out`/`word_idx` unchanged, `overflow` ← 1, `word_valid` ← 0.
- `word_valid` ← 0 on every non-completing edge.
- Transmit path:
  - `poci` = 0 while `csb` is high.
  - When `bit_cnt == 0`: `poci` = first bit of `tx_word` (combinational from `tx_word`).
  - Otherwise: `poci` = the outgoing end of `tx_shift`.
  - On an edge with `bit_cnt == 0`, `tx_shift` ← `tx_word` shifted by one toward the outgoing end. Otherwise `tx_shift` shifts by one, filling with 0.
- Transmit continues after overflow; `tx_word` is still loaded at each word start.
- A partial word when `csb` rises is discarded: no `word_valid`, and `word_out` is unchanged.

## Timing
- Receive latency: `word_out`, `word_idx` and `word_valid` update on the rising edge that samples the last bit of a word.
- `word_valid` stays high until the next rising edge, or until `csb`/`rstn` asserts.
- Back-to-back words: `word_valid` is high for one cycle in every WORD_W cycles, with no gap cycles required.
- `poci` changes only at rising edges or on `csb`/`bit_cnt` transitions. Its first bit is valid as soon as `csb` falls, provided `tx_word` is stable. This gives SPI mode 0 compatibility, with the master sampling on the rising edge.
- Simultaneous completion and saturation: the completing edge of word MAX_WORDS+1 sets `overflow`. `overflow` is visible after that edge.
- `csb` or `rstn` asserted mid-word: the clear takes effect immediately and asynchronously. No clock is required.

## Test plan
- WORD_W=8, MSB_FIRST=1: `csb` low, send 0xA5 MSB first → after the 8th edge `word_out`=0xA5, `word_idx`=0, `word_valid` high for exactly one cycle, `overflow`=0.
- MSB_FIRST=0: send bit stream 1,0,1,0,0,0,1,1 → `word_out`=0xC5.
- MAX_WORDS=4: burst of 0x11, 0x22, 0x33, 0x44, 0x55 → four `word_valid` strobes with `word_idx` 0..3; after the 40th edge `word_out`=0x44, `word_idx`=3, `overflow`=1; raising `csb` clears `overflow`, and `word_out` stays 0x44.
- `csb` raised after 3 bits, then a new burst sends 0x3C → no strobe for the partial word; `word_out`=0x3C with `word_idx`=0.
- `tx_word`=0xC3, MSB_FIRST=1 → `poci` sampled at edges 1..8 reads 1,1,0,0,0,0,1,1. A second word with `tx_word`=0x81 reads 1,0,0,0,0,0,0,1. `poci`=0 while `csb` is high.
- `rstn` pulsed low after 5 bits of a word following a completed 0x5A → all outputs 0 immediately, including `word_out`; a subsequent 0xFF receives correctly with `word_idx`=0.

Source files
------------

// File: rtl/spi_word_deser.sv
// Full-duplex SPI word engine: deserialises pico into WORD_W-bit words numbered within a csb burst,
// serialises tx_word onto poci, and flags bursts that run past MAX_WORDS words.
module spi_word_deser #(
    parameter int WORD_W    = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int MAX_WORDS = 4,
    parameter int IDX_W     = $clog2(MAX_WORDS)
) (
    input  logic              spi_clk,
    input  logic              rstn,
    input  logic              csb,
    input  logic              pico,
    input  logic [WORD_W-1:0] tx_word,
    output logic              poci,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    output logic [IDX_W-1:0]  word_idx,
    output logic              overflow
);

    localparam int CNT_W  = $clog2(WORD_W);
    localparam int DONE_W = $clog2(MAX_WORDS + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WORD_W - 1);
    localparam logic [DONE_W-1:0] MAX_DONE = DONE_W'(MAX_WORDS);

    logic                full_rstn;
    logic [CNT_W-1:0]    bit_cnt_q;
    logic [WORD_W-2:0]   rx_shift_q;
    logic [WORD_W-2:0]   rx_shift_d;
    logic [WORD_W-1:0]   tx_shift_q;
    logic [WORD_W-1:0]   tx_load;
    logic [WORD_W-1:0]   tx_adv;
    logic [DONE_W-1:0]   words_done_q;
    logic [WORD_W-1:0]   assembled;
    logic                tx_first;
    logic                tx_out;
    logic                last_bit;
    logic                word_start;
    logic                saturated;
    logic                accept;

    // csb high clears the burst-local state without needing a clock edge
    assign full_rstn  = rstn & ~csb;
    assign last_bit   = (bit_cnt_q == LAST_BIT);
    assign word_start = (bit_cnt_q == '0);
    assign saturated  = (words_done_q == MAX_DONE);
    assign accept     = ~csb & last_bit & ~saturated;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign assembled = {rx_shift_q, pico};
            if (WORD_W == 2) begin : g_narrow
                assign rx_shift_d = pico;
            end else begin : g_wide
                assign rx_shift_d = {rx_shift_q[WORD_W-3:0], pico};
            end
            assign tx_first = tx_word[WORD_W-1];
            assign tx_out   = tx_shift_q[WORD_W-1];
            assign tx_load  = {tx_word[WORD_W-2:0], 1'b0};
            assign tx_adv   = {tx_shift_q[WORD_W-2:0], 1'b0};
        end else begin : g_lsb_first
            assign assembled = {pico, rx_shift_q};
            if (WORD_W == 2) begin : g_narrow
                assign rx_shift_d = pico;
            end else begin : g_wide
                assign rx_shift_d = {pico, rx_shift_q[WORD_W-2:1]};
            end
            assign tx_first = tx_word[0];
            assign tx_out   = tx_shift_q[0];
            assign tx_load  = {1'b0, tx_word[WORD_W-1:1]};
            assign tx_adv   = {1'b0, tx_shift_q[WORD_W-1:1]};
        end
    endgenerate

    // First bit of a word comes straight from tx_word so it is ready as soon as csb falls
    assign poci = full_rstn & (word_start ? tx_first : tx_out);

    always_ff @(posedge spi_clk or negedge full_rstn) begin
        if (!full_rstn) begin
            bit_cnt_q    <= '0;
            rx_shift_q   <= '0;
            tx_shift_q   <= '0;
            words_done_q <= '0;
            word_valid   <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            bit_cnt_q  <= last_bit ? '0 : bit_cnt_q + 1'b1;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= word_start ? tx_load : tx_adv;
            word_valid <= accept;
            if (last_bit) begin
                if (saturated) begin
                    overflow <= 1'b1;
                end else begin
                    words_done_q <= words_done_q + 1'b1;
                end
            end
        end
    end

    // Received word survives csb high; only the chip-wide reset clears it
    always_ff @(posedge spi_clk or negedge rstn) begin
        if (!rstn) begin
            word_out <= '0;
            word_idx <= '0;
        end else if (accept) begin
            word_out <= assembled;
            word_idx <= words_done_q[IDX_W-1:0];
        end
    end

endmodule
